alu_writeback: RTL

- Receiving end of the ALU result interface.
- Samples the result bus (data, enable, destination tag, carry/overflow) and writes the data into a 16-entry register file. Holds the flags in registers.
- Keeps a per-register busy scoreboard: the issue stage marks a destination busy, and the matching writeback clears it.
- Supplies the two operand read ports that feed the ALU a/b inputs, with same-cycle write-through bypass.

---
 rtl/alu_pkg.sv | 17 +
 rtl/regfile_2r1w.sv | 42 ++++
 rtl/alu_writeback.sv | 86 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath and its writeback stage.
// Both sides import these so the result bus and register file agree on widths.
package alu_pkg;

  localparam int DATA_W     = 16;
  localparam int NREGS      = 16;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: 2 combinational read ports with same-cycle write bypass, 1 write port.
// Writes land on the clock edge; register 0 reads as zero and ignores writes; never stalls.
module regfile_2r1w
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS,
  parameter int ADDR_W = alu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // The write-enable term comes first so a floating wdata is never selected.
  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == '0)                   rdata_a = '0;
    else if (we && waddr == raddr_a)     rdata_a = wdata;

    rdata_b = mem[raddr_b];
    if (raddr_b == '0)                   rdata_b = '0;
    else if (we && waddr == raddr_b)     rdata_b = wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback: register file, busy scoreboard, flag registers and sticky wb_err.
// Results write in one edge (bypassed same cycle); issues are refused while the destination is busy.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS,
  parameter int ADDR_W = alu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_en,
  input  logic [DATA_W-1:0] res_data,
  input  logic [ADDR_W-1:0] res_dst,
  input  logic              res_carry,
  input  logic              res_overflow,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_a_busy,
  output logic              rd_b_busy,
  output logic              flag_carry_q,
  output logic              flag_overflow_q,
  output logic [NREGS-1:0]  busy_mask,
  output logic              wb_err
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  flags_t           flags_q;
  logic             wb_err_q;
  logic             wb_live;

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (res_en),
    .waddr   (res_dst),
    .wdata   (res_data),
    .raddr_a (rd_a_addr),
    .raddr_b (rd_b_addr),
    .rdata_a (rd_a_data),
    .rdata_b (rd_b_data)
  );

  assign wb_live = res_en && (res_dst != '0);

  // A writeback landing on the requested register frees it this cycle.
  assign issue_ready = issue_valid &&
                       ((issue_dst == '0) || !busy_q[issue_dst] ||
                        (res_en && res_dst == issue_dst));

  // Set is applied after clear so a same-cycle reuse keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_live)                          busy_d[res_dst]   = 1'b0;
    if (issue_ready && issue_dst != '0)   busy_d[issue_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      flags_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (res_en) begin
        flags_q.carry    <= res_carry;
        flags_q.overflow <= res_overflow;
      end
      if (wb_live && !busy_q[res_dst]) wb_err_q <= 1'b1;
    end
  end

  assign rd_a_busy       = busy_q[rd_a_addr] & ~(res_en && res_dst == rd_a_addr);
  assign rd_b_busy       = busy_q[rd_b_addr] & ~(res_en && res_dst == rd_b_addr);
  assign flag_carry_q    = flags_q.carry;
  assign flag_overflow_q = flags_q.overflow;
  assign busy_mask       = busy_q;
  assign wb_err          = wb_err_q;

endmodule
